// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: widths, the invalid tag and the {tag, val} entry that the
// ROB and reservation stations reuse.
package cdb_arbiter_pkg;

  localparam int COMMON_WIDTH   = 32;
  localparam int INST_TAG_WIDTH = 6;
  localparam int EX_UNIT_NUM    = 4;

  localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic [INST_TAG_WIDTH-1:0] tag;
    logic [COMMON_WIDTH-1:0]   val;
  } cdb_entry_t;

  function automatic logic tag_is_valid(input logic [INST_TAG_WIDTH-1:0] t);
    return t != TAG_INVALID;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result hand-over from the execution units plus the registered CDB broadcast.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC  = EX_UNIT_NUM,
  parameter int DATA_W = COMMON_WIDTH,
  parameter int TAG_W  = INST_TAG_WIDTH
) ();

  // Transfer on posedge when src_valid[i] & src_ready[i]; a unit holds src_valid
  // with stable tag/val until that edge. wb_en is a one-cycle pulse, no backpressure.
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_ready;
  logic [N_SRC*TAG_W-1:0]  src_tag;
  logic [N_SRC*DATA_W-1:0] src_val;
  logic                    wb_en;
  logic [TAG_W-1:0]        wb_tag;
  logic [DATA_W-1:0]       wb_val;

  modport master (
    output src_valid, src_tag, src_val,
    input  src_ready, wb_en, wb_tag, wb_val
  );

  modport slave (
    input  src_valid, src_tag, src_val,
    output src_ready, wb_en, wb_tag, wb_val
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module cdb_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          any_o
);

  int            sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr_i) + i;
      idx = PW'((sum >= N) ? (sum - N) : sum);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: one holding slot per execution unit, round-robin grant,
// registered broadcast. Flush drops every pending result but never a visible one.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC  = EX_UNIT_NUM,
  parameter int DATA_W = COMMON_WIDTH,
  parameter int TAG_W  = INST_TAG_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus,
  output logic          busy
);

  localparam int               PW      = $clog2(N_SRC);
  localparam logic [TAG_W-1:0] TAG_INV = TAG_W'(TAG_INVALID);

  logic [N_SRC-1:0]  slot_vld_q, slot_vld_d;
  logic [TAG_W-1:0]  slot_tag_q [N_SRC];
  logic [TAG_W-1:0]  slot_tag_d [N_SRC];
  logic [DATA_W-1:0] slot_val_q [N_SRC];
  logic [DATA_W-1:0] slot_val_d [N_SRC];
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              wb_en_q, wb_en_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [DATA_W-1:0] wb_val_q, wb_val_d;

  logic [N_SRC-1:0]  gnt;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [N_SRC-1:0]  ready;
  logic [N_SRC-1:0]  xfer;

  cdb_arbiter_rr_pick #(.N(N_SRC), .PW(PW)) u_pick (
    .req_i     (slot_vld_q),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // A granted slot frees up at this edge, so its unit may refill it back-to-back.
  assign ready = {N_SRC{~rst & ~flush}} & (~slot_vld_q | gnt);
  assign xfer  = bus.src_valid & ready;

  assign bus.src_ready = ready;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_tag    = wb_tag_q;
  assign bus.wb_val    = wb_val_q;
  assign busy          = (|slot_vld_q) | wb_en_q;

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_tag_d = slot_tag_q;
    slot_val_d = slot_val_q;
    rr_ptr_d   = rr_ptr_q;
    wb_en_d    = 1'b0;
    wb_tag_d   = TAG_INV;
    wb_val_d   = wb_val_q;

    if (gnt_any && !flush) begin
      wb_en_d  = 1'b1;
      wb_tag_d = slot_tag_q[gnt_idx];
      wb_val_d = slot_val_q[gnt_idx];
      rr_ptr_d = (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end

    for (int i = 0; i < N_SRC; i++) begin
      if (flush) begin
        slot_vld_d[i] = 1'b0;
      end else if (xfer[i]) begin
        // An invalid tag completes the handshake but leaves the slot empty.
        slot_vld_d[i] = bus.src_tag[i*TAG_W +: TAG_W] != TAG_INV;
        slot_tag_d[i] = bus.src_tag[i*TAG_W +: TAG_W];
        slot_val_d[i] = bus.src_val[i*DATA_W +: DATA_W];
      end else if (gnt[i]) begin
        slot_vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q <= '0;
      rr_ptr_q   <= '0;
      wb_en_q    <= 1'b0;
      wb_tag_q   <= TAG_INV;
      wb_val_q   <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      wb_en_q    <= wb_en_d;
      wb_tag_q   <= wb_tag_d;
      wb_val_q   <= wb_val_d;
    end
  end

  // Payload is qualified by slot_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    slot_tag_q <= slot_tag_d;
    slot_val_q <= slot_val_d;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with a broadcast scoreboard.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = EX_UNIT_NUM;
  localparam int TW = INST_TAG_WIDTH;
  localparam int DW = COMMON_WIDTH;
  localparam int W  = TW + DW;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  logic busy;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (bus.wb_en === 1'b1) begin
      chk("wb_tag_invalid_driven", 64'(bus.wb_tag == TAG_INVALID), 64'(0));
      if (exp_q.size() == 0) begin
        chk("wb_spurious", 64'(bus.wb_en), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("wb_data", 64'({bus.wb_tag, bus.wb_val}), 64'(e));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int u, input logic [TW-1:0] t, input logic [DW-1:0] v);
    bus.src_valid[u]         = 1'b1;
    bus.src_tag[u*TW +: TW]  = t;
    bus.src_val[u*DW +: DW]  = v;
  endtask

  task automatic expect_wb(input logic [TW-1:0] t, input logic [DW-1:0] v);
    exp_q.push_back({t, v});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.src_valid = '1;
    bus.src_tag   = '0;
    bus.src_val   = '0;

    // 1: reset with every unit offering
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(bus.src_ready), 64'(0));
      chk("rst_wb_en", 64'(bus.wb_en), 64'(0));
      chk("rst_wb_tag", 64'(bus.wb_tag), 64'(TAG_INVALID));
      chk("rst_busy", 64'(busy), 64'(0));
    end
    rst           = 1'b0;
    bus.src_valid = '0;
    tick();

    // 2: single source, 2-cycle latency
    set_src(2, TW'(5), 32'hDEAD_BEEF);
    expect_wb(TW'(5), 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_ready", 64'(bus.src_ready[2]), 64'(1));
    @(posedge clk);
    #1 bus.src_valid = '0;
    @(negedge clk);
    chk("t2_early_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t2_busy", 64'(busy), 64'(1));
    @(posedge clk);
    @(negedge clk);
    chk("t2_wb_en", 64'(bus.wb_en), 64'(1));
    chk("t2_wb_tag", 64'(bus.wb_tag), 64'(5));
    chk("t2_wb_val", 64'(bus.wb_val), 64'(32'hDEAD_BEEF));
    @(posedge clk);
    @(negedge clk);
    chk("t2_pulse_end", 64'(bus.wb_en), 64'(0));
    chk("t2_idle_busy", 64'(busy), 64'(0));

    // 4: pointer sits at 3 after the grant to unit 2; slots 0 and 3 compete
    tick();
    set_src(0, TW'(8'h0A), 32'hA000_000A);
    set_src(3, TW'(8'h0D), 32'hD000_000D);
    expect_wb(TW'(8'h0D), 32'hD000_000D);
    expect_wb(TW'(8'h0A), 32'hA000_000A);
    @(posedge clk);
    #1 bus.src_valid = '0;
    @(negedge clk);
    chk("t4_no_wb_yet", 64'(bus.wb_en), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk("t4_first_slot3", 64'(bus.wb_tag), 64'(8'h0D));
    @(posedge clk);
    @(negedge clk);
    chk("t4_wrap_slot0", 64'(bus.wb_tag), 64'(8'h0A));
    chk("t4_wrap_wb_en", 64'(bus.wb_en), 64'(1));

    // 3: full contention from a freshly reset pointer
    tick();
    do_reset(2);
    for (int u = 0; u < N; u++) set_src(u, TW'(u + 1), DW'(32'h100 + u));
    for (int k = 0; k < 12; k++) expect_wb(TW'(k % N + 1), DW'(32'h100 + k % N));
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      if (k == 7) #1 bus.src_valid = '0;
      @(negedge clk);
      chk("t3_wb_en", 64'(bus.wb_en), 64'(1));
      chk("t3_order", 64'(bus.wb_tag), 64'(k % N + 1));
      if (k <= 7) chk("t3_ready_onehot", 64'(bus.src_ready), 64'(1) << ((k + 1) % N));
    end
    @(posedge clk);
    @(negedge clk);
    chk("t3_drained", 64'(bus.wb_en), 64'(0));
    chk("t3_busy", 64'(busy), 64'(0));

    // 5: flush with three occupied slots while units keep offering
    tick();
    for (int u = 0; u < 3; u++) set_src(u, TW'(8'h11 + u), DW'(32'h1100 + u));
    @(posedge clk);
    #1;
    flush = 1'b1;
    for (int u = 0; u < 3; u++) set_src(u, TW'(8'h21 + u), DW'(32'h2100 + u));
    @(negedge clk);
    chk("t5_flush_ready", 64'(bus.src_ready), 64'(0));
    chk("t5_flush_busy", 64'(busy), 64'(1));
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("t5_post_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t5_post_ready", 64'(bus.src_ready), 64'({N{1'b1}}));
    chk("t5_post_busy", 64'(busy), 64'(0));
    for (int u = 0; u < 3; u++) expect_wb(TW'(8'h21 + u), DW'(32'h2100 + u));
    @(posedge clk);
    #1 bus.src_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t5_new_order", 64'(bus.wb_tag), 64'(8'h21 + k));
    end
    @(posedge clk);
    @(negedge clk);
    chk("t5_drained", 64'(bus.wb_en), 64'(0));

    // 6: unit 1 streams 7, invalid, 9 back-to-back
    tick();
    expect_wb(TW'(7), 32'h7777_0007);
    expect_wb(TW'(9), 32'h9999_0009);
    set_src(1, TW'(7), 32'h7777_0007);
    @(negedge clk);
    chk("t6_ready0", 64'(bus.src_ready[1]), 64'(1));
    @(posedge clk);
    #1 set_src(1, TAG_INVALID, 32'hBAD0_0000);
    @(negedge clk);
    chk("t6_ready1", 64'(bus.src_ready[1]), 64'(1));
    @(posedge clk);
    #1 set_src(1, TW'(9), 32'h9999_0009);
    @(negedge clk);
    chk("t6_wb7_en", 64'(bus.wb_en), 64'(1));
    chk("t6_wb7_tag", 64'(bus.wb_tag), 64'(7));
    chk("t6_ready2", 64'(bus.src_ready[1]), 64'(1));
    @(posedge clk);
    #1 bus.src_valid = '0;
    @(negedge clk);
    chk("t6_gap", 64'(bus.wb_en), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk("t6_wb9_tag", 64'(bus.wb_tag), 64'(9));
    @(posedge clk);
    @(negedge clk);
    chk("t6_done_wb_en", 64'(bus.wb_en), 64'(0));
    chk("t6_done_busy", 64'(busy), 64'(0));

    // ---------------- report ----------------
    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
